// File: rtl/mhp_rx_parser.sv
// mhp_rx_parser: drains one MHP frame from the RX byte FIFO and
// deserialises it into header fields and a payload register.
//
// Ports:
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_rdata           FIFO read data, valid the cycle after o_rreq
//   i_rready          FIFO non-empty, held high for a whole frame
//   o_rreq            registered FIFO read request
//   o_busy            frame in progress (start .. o_valid cycle)
//   o_valid           one-cycle strobe, fields stable until next frame
//   o_scs/o_dst/o_src/o_size/o_dir/o_type  header fields
//   o_payload         payload, byte k at [8k+7:8k], unreceived bytes 0
//   o_err_len         byte count does not match SIZE, or SIZE too big
//   o_err_scs         nonzero SCS that differs from the byte sum
module mhp_rx_parser #(
    parameter int MAX_PAYLOAD = 42,
    parameter int HDR_BYTES   = 9
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [7:0]               i_rdata,
    input  logic                     i_rready,
    output logic                     o_rreq,
    output logic                     o_busy,
    output logic                     o_valid,
    output logic [15:0]              o_scs,
    output logic [15:0]              o_dst,
    output logic [15:0]              o_src,
    output logic [15:0]              o_size,
    output logic                     o_dir,
    output logic [6:0]               o_type,
    output logic [8*MAX_PAYLOAD-1:0] o_payload,
    output logic                     o_err_len,
    output logic                     o_err_scs
);

    localparam logic [7:0]  LP_HDR8  = 8'(HDR_BYTES);
    localparam logic [16:0] LP_HDR17 = 17'(HDR_BYTES);
    localparam logic [15:0] LP_MAX16 = 16'(MAX_PAYLOAD);

    typedef enum logic [1:0] {
        S_SYNC,
        S_IDLE,
        S_RX,
        S_CHECK
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                     r_rreq;
    logic                     r_rd_v;
    logic                     r_busy;
    logic                     r_valid;
    logic [7:0]               r_byte_cnt;
    logic [15:0]              r_sum;
    logic [15:0]              r_scs;
    logic [15:0]              r_dst;
    logic [15:0]              r_src;
    logic [15:0]              r_size;
    logic                     r_dir;
    logic [6:0]               r_type;
    logic [8*MAX_PAYLOAD-1:0] r_payload;
    logic                     r_err_len;
    logic                     r_err_scs;

    logic       w_start;
    logic       w_done;
    logic       w_rreq_d;
    logic       w_capture;
    logic [7:0] w_pidx;
    logic       w_err_len;
    logic       w_err_scs;

    // ---------------- state register ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- next state / control ----------------
    always_comb begin
        w_next   = r_state;
        w_start  = 1'b0;
        w_done   = 1'b0;
        w_rreq_d = 1'b0;
        case (r_state)
            S_SYNC: begin
                // wait out any frame that was cut by reset
                if (!i_rready) begin
                    w_next = S_IDLE;
                end
            end
            S_IDLE: begin
                if (i_rready) begin
                    w_next   = S_RX;
                    w_start  = 1'b1;
                    w_rreq_d = 1'b1;
                end
            end
            S_RX: begin
                // drained: no request pending and no read in flight
                if (!r_rreq && !r_rd_v) begin
                    w_next = S_CHECK;
                    w_done = 1'b1;
                end else begin
                    w_rreq_d = i_rready;
                end
            end
            S_CHECK: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_SYNC;
            end
        endcase
    end

    // ---------------- control registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rreq  <= 1'b0;
            r_rd_v  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_rreq  <= w_rreq_d;
            r_rd_v  <= r_rreq;
            r_valid <= w_done;
            if (w_start) begin
                r_busy <= 1'b1;
            end else if (r_state == S_CHECK) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign w_capture = (r_state == S_RX) && r_rd_v;
    assign w_pidx    = r_byte_cnt - LP_HDR8;

    assign w_err_len = ({9'd0, r_byte_cnt} != ({1'b0, r_size} + LP_HDR17))
                    || (r_size > LP_MAX16);
    // SCS of zero means the sender did not compute one
    assign w_err_scs = (r_scs != 16'h0000) && (r_scs != r_sum);

    // ---------------- datapath ----------------
    // Fields are cleared at frame start rather than on IDLE entry so the
    // previous result stays readable until a new frame begins.
    always_ff @(posedge i_clk) begin
        if (i_rst || w_start) begin
            r_byte_cnt <= '0;
            r_sum      <= '0;
            r_scs      <= '0;
            r_dst      <= '0;
            r_src      <= '0;
            r_size     <= '0;
            r_dir      <= 1'b0;
            r_type     <= '0;
            r_payload  <= '0;
            r_err_len  <= 1'b0;
            r_err_scs  <= 1'b0;
        end else if (w_capture) begin
            case (r_byte_cnt)
                8'd0: r_scs[15:8]  <= i_rdata;
                8'd1: r_scs[7:0]   <= i_rdata;
                8'd2: r_dst[15:8]  <= i_rdata;
                8'd3: r_dst[7:0]   <= i_rdata;
                8'd4: r_src[15:8]  <= i_rdata;
                8'd5: r_src[7:0]   <= i_rdata;
                8'd6: r_size[15:8] <= i_rdata;
                8'd7: r_size[7:0]  <= i_rdata;
                8'd8: {r_dir, r_type} <= i_rdata;
                default: begin
                    // bytes past the payload buffer are counted only
                    for (int k = 0; k < MAX_PAYLOAD; k++) begin
                        if (w_pidx == 8'(k)) begin
                            r_payload[8*k +: 8] <= i_rdata;
                        end
                    end
                end
            endcase
            if (r_byte_cnt != 8'hFF) begin
                r_byte_cnt <= r_byte_cnt + 8'd1;
            end
            if (r_byte_cnt >= 8'd2) begin
                r_sum <= r_sum + {8'h00, i_rdata};
            end
        end else if (w_done) begin
            r_err_len <= w_err_len;
            r_err_scs <= w_err_scs;
        end
    end

    assign o_rreq    = r_rreq;
    assign o_busy    = r_busy;
    assign o_valid   = r_valid;
    assign o_scs     = r_scs;
    assign o_dst     = r_dst;
    assign o_src     = r_src;
    assign o_size    = r_size;
    assign o_dir     = r_dir;
    assign o_type    = r_type;
    assign o_payload = r_payload;
    assign o_err_len = r_err_len;
    assign o_err_scs = r_err_scs;

endmodule

// File: tb/tb_mhp_rx_parser.sv
// tb_mhp_rx_parser: directed frames through a FIFO model that never
// lets a read request run past the end of the current frame.
module tb_mhp_rx_parser;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic [7:0]   i_rdata;
    logic         i_rready;
    logic         o_rreq;
    logic         o_busy;
    logic         o_valid;
    logic [15:0]  o_scs;
    logic [15:0]  o_dst;
    logic [15:0]  o_src;
    logic [15:0]  o_size;
    logic         o_dir;
    logic [6:0]   o_type;
    logic [335:0] o_payload;
    logic         o_err_len;
    logic         o_err_scs;

    mhp_rx_parser dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_rdata   (i_rdata),
        .i_rready  (i_rready),
        .o_rreq    (o_rreq),
        .o_busy    (o_busy),
        .o_valid   (o_valid),
        .o_scs     (o_scs),
        .o_dst     (o_dst),
        .o_src     (o_src),
        .o_size    (o_size),
        .o_dir     (o_dir),
        .o_type    (o_type),
        .o_payload (o_payload),
        .o_err_len (o_err_len),
        .o_err_scs (o_err_scs)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [15:0]  scs;
        logic [15:0]  dst;
        logic [15:0]  src;
        logic [15:0]  size;
        logic [7:0]   dt;
        logic [335:0] pay;
        logic         el;
        logic         es;
    } res_t;

    res_t         res [0:3];
    logic [7:0]   fb [0:255];
    int           ends [0:3];
    int           fn, rp, lim, nends, fi, gapc, gap, nv;
    int           n_chk = 0;
    int           n_err = 0;
    logic         busy_seen;
    logic         bad;
    logic [335:0] exp_pay;

    task automatic chk(input string tag, input logic [335:0] got,
                       input logic [335:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: starts and ends at a falling edge
    task automatic tick();
        logic pop;
        if (rp == lim && fi + 1 < nends) begin
            if (gapc >= gap) begin
                fi++;
                lim  = ends[fi];
                gapc = 0;
            end else begin
                gapc++;
            end
        end
        pop      = o_rreq && (rp < lim);
        i_rready = ((lim - rp) > (o_rreq ? 1 : 0));
        @(posedge i_clk);
        #1;
        if (pop) begin
            i_rdata = fb[rp];
            rp++;
        end
        @(negedge i_clk);
        if (o_busy) busy_seen = 1'b1;
        if (o_valid) begin
            if (nv < 4) begin
                res[nv].scs  = o_scs;
                res[nv].dst  = o_dst;
                res[nv].src  = o_src;
                res[nv].size = o_size;
                res[nv].dt   = {o_dir, o_type};
                res[nv].pay  = o_payload;
                res[nv].el   = o_err_len;
                res[nv].es   = o_err_scs;
            end
            nv++;
        end
    endtask

    task automatic clr();
        fn = 0; rp = 0; lim = 0; nends = 0; fi = 0; gapc = 0;
    endtask

    task automatic pb(input logic [7:0] b);
        fb[fn] = b;
        fn++;
    endtask

    task automatic hdr(input logic [15:0] scs, input logic [15:0] dst,
                       input logic [15:0] src, input logic [15:0] size,
                       input logic [7:0] dt);
        pb(scs[15:8]);  pb(scs[7:0]);
        pb(dst[15:8]);  pb(dst[7:0]);
        pb(src[15:8]);  pb(src[7:0]);
        pb(size[15:8]); pb(size[7:0]);
        pb(dt);
    endtask

    task automatic endf();
        ends[nends] = fn;
        nends++;
    endtask

    task automatic go(input string tag, input int nexp);
        fi = 0; lim = ends[0]; gapc = 0; nv = 0; busy_seen = 1'b0;
        for (int i = 0; i < 400 && !(nv >= nexp && rp == fn); i++) tick();
        repeat (3) tick();
        chk({tag, ".n_valid"}, 336'(nv), 336'(nexp));
    endtask

    task automatic chk_res(input int k, input string t,
                           input logic [15:0] scs, input logic [15:0] dst,
                           input logic [15:0] src, input logic [15:0] size,
                           input logic [7:0] dt, input logic el,
                           input logic es);
        chk({t, ".scs"},  336'(res[k].scs),  336'(scs));
        chk({t, ".dst"},  336'(res[k].dst),  336'(dst));
        chk({t, ".src"},  336'(res[k].src),  336'(src));
        chk({t, ".size"}, 336'(res[k].size), 336'(size));
        chk({t, ".dt"},   336'(res[k].dt),   336'(dt));
        chk({t, ".elen"}, 336'(res[k].el),   336'(el));
        chk({t, ".escs"}, 336'(res[k].es),   336'(es));
    endtask

    task automatic f1(input logic [15:0] scs);
        clr();
        hdr(scs, 16'h0001, 16'hFFFF, 16'h0003, 8'h83);
        pb(8'h02); pb(8'h20); pb(8'h60);
        endf();
    endtask

    task automatic pat(input logic [15:0] size, input int n);
        clr();
        hdr(16'h0000, 16'h0A0B, 16'h0C0D, size, 8'h11);
        exp_pay = '0;
        for (int k = 0; k < n; k++) begin
            pb(8'(k + 1));
            if (k < 42) exp_pay[8*k +: 8] = 8'(k + 1);
        end
        endf();
    endtask

    initial begin
        i_rst = 1'b1; i_rready = 1'b0; i_rdata = 8'h00;
        gap = 1; nv = 0; busy_seen = 1'b0;
        for (int k = 0; k < 4; k++) res[k] = '0;
        clr();
        repeat (3) tick();
        chk("rst.hdr", 336'({o_scs, o_dst, o_src, o_size, o_dir, o_type}),
            336'(0));
        chk("rst.pay", o_payload, 336'(0));
        chk("rst.ctl", 336'({o_rreq, o_busy, o_valid, o_err_len, o_err_scs}),
            336'(0));
        i_rst = 1'b0;
        repeat (2) tick();

        // basic frame, unchecked SCS
        f1(16'h0000);
        go("t1", 1);
        chk_res(0, "t1", 16'h0000, 16'h0001, 16'hFFFF, 16'h0003, 8'h83,
                1'b0, 1'b0);
        chk("t1.pay", res[0].pay, 336'h602002);
        chk("t1.busy_seen", 336'(busy_seen), 336'(1));
        chk("t1.busy_end", 336'(o_busy), 336'(0));
        chk("t1.hold_dst", 336'(o_dst), 336'h0001);

        // sum of bytes 2..11 = 0x0307
        f1(16'h0307);
        go("t2a", 1);
        chk("t2a.escs", 336'(res[0].es), 336'(0));
        chk("t2a.elen", 336'(res[0].el), 336'(0));
        f1(16'h0306);
        go("t2b", 1);
        chk("t2b.escs", 336'(res[0].es), 336'(1));
        chk("t2b.scs", 336'(res[0].scs), 336'h0306);

        // SIZE=5 but only 3 payload bytes
        clr();
        hdr(16'h0000, 16'h0002, 16'h0003, 16'h0005, 8'h01);
        pb(8'h11); pb(8'h22); pb(8'h33);
        endf();
        go("t3", 1);
        chk_res(0, "t3", 16'h0000, 16'h0002, 16'h0003, 16'h0005, 8'h01,
                1'b1, 1'b0);
        chk("t3.pay", res[0].pay, 336'h332211);

        // short frame: 5 header bytes only
        clr();
        pb(8'h12); pb(8'h34); pb(8'h56); pb(8'h78); pb(8'h9A);
        endf();
        go("t4", 1);
        chk_res(0, "t4", 16'h1234, 16'h5678, 16'h9A00, 16'h0000, 8'h00,
                1'b1, 1'b1);

        // SIZE=42 with 50 payload bytes
        pat(16'd42, 50);
        go("t5", 1);
        chk_res(0, "t5", 16'h0000, 16'h0A0B, 16'h0C0D, 16'd42, 8'h11,
                1'b1, 1'b0);
        chk("t5.pay", res[0].pay, exp_pay);
        chk("t5.last", 336'(res[0].pay[335:328]), 336'h2A);

        // SIZE=42 exact fit
        pat(16'd42, 42);
        go("t6", 1);
        chk("t6.elen", 336'(res[0].el), 336'(0));
        chk("t6.pay", res[0].pay, exp_pay);

        // SIZE=43 exact count but over capacity
        pat(16'd43, 43);
        go("t7", 1);
        chk("t7.elen", 336'(res[0].el), 336'(1));
        chk("t7.pay", res[0].pay, exp_pay);

        // reset after 4 bytes with the FIFO still full
        f1(16'h0000);
        fi = 0; lim = ends[0]; gapc = 0; nv = 0;
        for (int i = 0; i < 20 && rp < 4; i++) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("t8.ctl", 336'({o_rreq, o_busy, o_valid}), 336'(0));
        chk("t8.dst", 336'(o_dst), 336'(0));
        bad = 1'b0;
        repeat (6) begin
            tick();
            if (o_rreq) bad = 1'b1;
        end
        chk("t8.rreq_hold", 336'(bad), 336'(0));
        chk("t8.no_valid", 336'(nv), 336'(0));
        rp = lim;
        repeat (3) tick();
        clr();
        hdr(16'h0000, 16'hBEEF, 16'h1357, 16'h0001, 8'h7F);
        pb(8'hC3);
        endf();
        go("t8b", 1);
        chk_res(0, "t8b", 16'h0000, 16'hBEEF, 16'h1357, 16'h0001, 8'h7F,
                1'b0, 1'b0);
        chk("t8b.pay", res[0].pay, 336'hC3);

        // two frames with a one-cycle gap
        clr();
        hdr(16'h0000, 16'h1234, 16'hABCD, 16'h0002, 8'h05);
        pb(8'hAA); pb(8'h55);
        endf();
        hdr(16'h0000, 16'h4321, 16'h0F0F, 16'h0001, 8'hFF);
        pb(8'h7E);
        endf();
        gap = 1;
        go("t9", 2);
        chk_res(0, "t9a", 16'h0000, 16'h1234, 16'hABCD, 16'h0002, 8'h05,
                1'b0, 1'b0);
        chk("t9a.pay", res[0].pay, 336'h55AA);
        chk_res(1, "t9b", 16'h0000, 16'h4321, 16'h0F0F, 16'h0001, 8'hFF,
                1'b0, 1'b0);
        chk("t9b.pay", res[1].pay, 336'h7E);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
